// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // A frame length is usable only if non-empty and it fits the memory.
  function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                     input logic [LEN_W-1:0] max_len);
    return (len != {LEN_W{1'b0}}) && (len <= max_len);
  endfunction

endpackage

// File: rtl/imem_loader_checksum.sv
// 8-bit running modular sum of payload bytes; o_zero reports whether
// accepting i_byte as the checksum would close the sum to zero.
module loader_checksum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_acc,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_zero
);

  logic [BYTE_W-1:0] r_sum;
  logic [BYTE_W-1:0] w_sum_next;

  assign w_sum_next = r_sum + i_byte;
  assign o_zero     = (w_sum_next == {BYTE_W{1'b0}});

  // Running sum register: clear at frame start, accumulate each payload byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sum <= {BYTE_W{1'b0}};
    end else if (i_clear) begin
      r_sum <= {BYTE_W{1'b0}};
    end else if (i_acc) begin
      r_sum <= w_sum_next;
    end else begin
      r_sum <= r_sum;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU in reset
// until a frame with a correct checksum has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH  = 512,
  parameter int          ADDR_W = 9,
  parameter logic [7:0]  SYNC   = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(DEPTH);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_fire;
  logic [7:0]         r_len_hi;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_rx;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W:0]    r_count;
  logic [ADDR_W:0]    w_count_inc;
  logic               w_last;
  logic               w_sum_zero;

  assign w_fire      = in_valid && in_ready;
  assign w_len_rx    = {r_len_hi, in_data};
  assign w_count_inc = r_count + CNT_ONE;
  assign w_last      = (LEN_W'(w_count_inc) == r_len);
  assign byte_count  = r_count;

  loader_checksum u_checksum (
    .clk     (clk),
    .reset   (reset),
    .i_clear ((r_state == ST_LEN_LO) && w_fire),
    .i_acc   ((r_state == ST_DATA) && w_fire),
    .i_byte  (in_data),
    .o_zero  (w_sum_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; terminal states leave only on restart.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_fire && (in_data == SYNC)) w_state_next = ST_LEN_HI;
                 else                             w_state_next = ST_IDLE;
      ST_LEN_HI: if (w_fire) w_state_next = ST_LEN_LO;
                 else        w_state_next = ST_LEN_HI;
      ST_LEN_LO: if (w_fire) w_state_next = len_legal(w_len_rx, MAX_LEN) ? ST_DATA : ST_ERROR;
                 else        w_state_next = ST_LEN_LO;
      ST_DATA:   if (w_fire && w_last) w_state_next = ST_CHECK;
                 else                  w_state_next = ST_DATA;
      ST_CHECK:  if (w_fire) w_state_next = w_sum_zero ? ST_DONE : ST_ERROR;
                 else        w_state_next = ST_CHECK;
      ST_DONE:   if (restart) w_state_next = ST_IDLE;
                 else         w_state_next = ST_DONE;
      ST_ERROR:  if (restart) w_state_next = ST_IDLE;
                 else         w_state_next = ST_ERROR;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (r_state)
      ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: in_ready = 1'b1;
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERROR: error = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  // Length capture, address/count tracking and the one-cycle memory write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_len_hi <= 8'd0;
      r_len    <= {LEN_W{1'b0}};
      r_addr   <= {ADDR_W{1'b0}};
      r_count  <= {(ADDR_W+1){1'b0}};
      mem_we   <= 1'b0;
      mem_addr <= {ADDR_W{1'b0}};
      mem_data <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        ST_LEN_HI: if (w_fire) r_len_hi <= in_data;
        ST_LEN_LO: if (w_fire) begin
          r_len   <= w_len_rx;
          r_addr  <= {ADDR_W{1'b0}};
          r_count <= {(ADDR_W+1){1'b0}};
        end
        ST_DATA: if (w_fire) begin
          mem_we   <= 1'b1;
          mem_addr <= r_addr;
          mem_data <= in_data;
          r_addr   <= r_addr + ADDR_ONE;
          r_count  <= w_count_inc;
        end
        ST_DONE, ST_ERROR: if (restart) r_count <= {(ADDR_W+1){1'b0}};
        default: r_len_hi <= r_len_hi;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level model.
module tb_imem_loader;

  localparam int         DEPTH = 512;
  localparam logic [7:0] SYNC  = 8'hA5;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       restart = 1'b0;
  logic       in_ready, mem_we, cpu_hold, done, error;
  logic [8:0] mem_addr;
  logic [7:0] mem_data;
  logic [9:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [16:0] got_q[$];
  int          got_cyc[$];
  logic [16:0] exp_q[$];
  logic        exp_done, exp_error;
  int          exp_count;

  localparam logic [31:0] RESET_TUPLE = {1'b1, 1'b0, 9'd0, 8'd0, 1'b1, 1'b0, 1'b0, 10'd0};

  imem_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_hold(cpu_hold), .done(done), .error(error),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_data});
      got_cyc.push_back(cyc);
    end
  end

  // Frame-level model: find the first SYNC, read a big-endian length, list writes, judge checksum.
  task automatic model_frame(input bq_t s);
    int k, len, sum;
    exp_q.delete();
    exp_done = 1'b0; exp_error = 1'b0; exp_count = 0;
    k = 0;
    while (k < s.size() && s[k] != SYNC) k++;
    if (k + 2 >= s.size()) return;
    len = int'(s[k+1]) * 256 + int'(s[k+2]);
    if (len == 0 || len > DEPTH) begin
      exp_error = 1'b1;
      return;
    end
    sum = 0;
    for (int j = 0; j < len; j++) begin
      exp_q.push_back({9'(j), s[k+3+j]});
      sum += int'(s[k+3+j]);
    end
    sum += int'(s[k+3+len]);
    exp_count = len;
    exp_done  = ((sum % 256) == 0);
    exp_error = !exp_done;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = $urandom_range(max_gap, 0);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send(input bq_t s, input int max_gap);
    foreach (s[i]) drive_byte(s[i], max_gap);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, byte_count} !== RESET_TUPLE) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h",
               {in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, byte_count}, RESET_TUPLE);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, cpu_hold, done, error, mem_we} !== 5'b11000) begin
      n_fail++;
      $display("FAIL idle_hold: got %b want 11000", {in_ready, cpu_hold, done, error, mem_we});
    end
  endtask

  task automatic test_good_frame();
    bq_t s;
    int  bad;
    s = {8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    got_q.delete(); got_cyc.delete();
    model_frame(s);
    send(s, 0);
    n_tests++;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (bad == 0 && got_q[i] !== exp_q[i]) bad = 2 + i;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL good_writes: got %0d writes want %0d (code %0d)", got_q.size(), exp_q.size(), bad);
    end
    n_tests++;
    bad = 0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] != 1) bad = 1;
    if (bad != 0 || got_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d writes, gap flag %0d want 4 consecutive", got_cyc.size(), bad);
    end
    n_tests++;
    if ({done, error, cpu_hold, byte_count, in_ready} !== {1'b1, 1'b0, 1'b0, 10'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL good_status: got %b want %b", {done, error, cpu_hold, byte_count, in_ready},
               {1'b1, 1'b0, 1'b0, 10'd4, 1'b0});
    end
  endtask

  task automatic test_bad_checksum();
    bq_t s;
    int  bad;
    pulse_restart();
    s = {8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h57};
    got_q.delete();
    model_frame(s);
    send(s, 0);
    n_tests++;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (bad == 0 && got_q[i] !== exp_q[i]) bad = 2 + i;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL badsum_writes: got %0d writes want %0d (code %0d)", got_q.size(), exp_q.size(), bad);
    end
    n_tests++;
    if ({done, error, cpu_hold, byte_count} !== {exp_done, exp_error, !exp_done, 10'(exp_count)}) begin
      n_fail++;
      $display("FAIL badsum_status: got %b want %b", {done, error, cpu_hold, byte_count},
               {exp_done, exp_error, !exp_done, 10'(exp_count)});
    end
  endtask

  task automatic test_len_errors();
    bq_t s;
    for (int f = 0; f < 2; f++) begin
      pulse_restart();
      if (f == 0) s = {8'hA5, 8'h00, 8'h00, 8'h12};
      else        s = {8'hA5, 8'h02, 8'h01, 8'h12};
      got_q.delete();
      send(s, 1);
      n_tests++;
      if ({got_q.size() == 0, done, error, cpu_hold, in_ready} !== 5'b10110) begin
        n_fail++;
        $display("FAIL len_error_%0d: got writes=%0d d/e/h/r=%b want 0 writes and 0110",
                 f, got_q.size(), {done, error, cpu_hold, in_ready});
      end
    end
  endtask

  task automatic test_resync_gaps();
    bq_t s;
    int  bad;
    pulse_restart();
    s = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h7E, 8'h82};
    got_q.delete();
    model_frame(s);
    send(s, 3);
    n_tests++;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (bad == 0 && got_q[i] !== exp_q[i]) bad = 2 + i;
    if (bad != 0 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL resync_writes: got %0d writes want 1 of 000_7e (code %0d)", got_q.size(), bad);
    end
    n_tests++;
    if ({done, error, cpu_hold, byte_count} !== {1'b1, 1'b0, 1'b0, 10'd1}) begin
      n_fail++;
      $display("FAIL resync_status: got %b want 1_0_0_0000000001", {done, error, cpu_hold, byte_count});
    end
  endtask

  task automatic test_reset_mid_frame();
    bq_t s;
    int  bad, sum;
    pulse_restart();
    got_q.delete();
    s = {8'hA5, 8'h00, 8'h04, 8'h11, 8'h22};
    foreach (s[i]) drive_byte(s[i], 0);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, byte_count} !== RESET_TUPLE
        || got_q.size() != 2) begin
      n_fail++;
      $display("FAIL mid_reset: got %h with %0d writes want %h with 2 writes",
               {in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, byte_count},
               got_q.size(), RESET_TUPLE);
    end
    reset = 1'b1;
    @(negedge clk);
    s = {8'h33, 8'h44, 8'hA5, 8'h00, 8'h04};
    sum = 0;
    repeat (4) begin
      s.push_back(8'($urandom));
      sum += int'(s[s.size()-1]);
    end
    s.push_back(8'((256 - sum % 256) % 256));
    got_q.delete();
    model_frame(s);
    send(s, 2);
    n_tests++;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (bad == 0 && got_q[i] !== exp_q[i]) bad = 2 + i;
    if (bad != 0 || exp_done !== 1'b1 || done !== 1'b1 || byte_count !== 10'd4) begin
      n_fail++;
      $display("FAIL after_reset_frame: got %0d writes done=%b count=%0d want %0d writes done=1 count=4 (code %0d)",
               got_q.size(), done, byte_count, exp_q.size(), bad);
    end
  endtask

  task automatic test_restart();
    bq_t s;
    int  bad;
    pulse_restart();
    n_tests++;
    if ({in_ready, cpu_hold, done, error, byte_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL restart_done: got %b want 1100_0000000000", {in_ready, cpu_hold, done, error, byte_count});
    end
    s = {8'hA5, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
    got_q.delete();
    model_frame(s);
    for (int i = 0; i < 4; i++) drive_byte(s[i], 0);
    pulse_restart();
    n_tests++;
    if ({in_ready, byte_count, error} !== {1'b1, 10'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_in_data: got %b want 1_0000000001_0", {in_ready, byte_count, error});
    end
    for (int i = 4; i < s.size(); i++) drive_byte(s[i], 0);
    repeat (2) @(negedge clk);
    n_tests++;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (bad == 0 && got_q[i] !== exp_q[i]) bad = 2 + i;
    if (bad != 0 || done !== exp_done || byte_count !== 10'(exp_count)) begin
      n_fail++;
      $display("FAIL restart_ignored_frame: got %0d writes done=%b want %0d writes done=%b (code %0d)",
               got_q.size(), done, exp_q.size(), exp_done, bad);
    end
  endtask

  task automatic test_max_len();
    bq_t s;
    int  bad, sum;
    pulse_restart();
    s = {8'hA5, 8'h02, 8'h00};
    sum = 0;
    repeat (DEPTH) begin
      s.push_back(8'($urandom));
      sum += int'(s[s.size()-1]);
    end
    s.push_back(8'((256 - sum % 256) % 256));
    got_q.delete();
    model_frame(s);
    send(s, 0);
    n_tests++;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (bad == 0 && got_q[i] !== exp_q[i]) bad = 2 + i;
    if (bad != 0 || got_q.size() != DEPTH || got_q[DEPTH-1][16:8] !== 9'd511) begin
      n_fail++;
      $display("FAIL max_len_writes: got %0d writes want 512 ending at addr 511 (code %0d)", got_q.size(), bad);
    end
    n_tests++;
    if ({done, error, cpu_hold, byte_count} !== {1'b1, 1'b0, 1'b0, 10'd512}) begin
      n_fail++;
      $display("FAIL max_len_status: got %b want 1_0_0_1000000000", {done, error, cpu_hold, byte_count});
    end
  endtask

  task automatic test_random();
    bq_t        s;
    int         bad, len, sum;
    logic [7:0] b;
    for (int f = 0; f < 20; f++) begin
      pulse_restart();
      s.delete();
      repeat ($urandom_range(3, 0)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        s.push_back(b);
      end
      s.push_back(SYNC);
      if ($urandom_range(7, 0) == 0) len = ($urandom_range(1, 0) == 1) ? 0 : int'($urandom_range(65535, 513));
      else                           len = int'($urandom_range(32, 1));
      s.push_back(8'(len >> 8));
      s.push_back(8'(len));
      if (len >= 1 && len <= DEPTH) begin
        sum = 0;
        repeat (len) begin
          b = 8'($urandom);
          s.push_back(b);
          sum += int'(b);
        end
        b = 8'((256 - sum % 256) % 256);
        if ($urandom_range(2, 0) == 0) b = b + 8'($urandom_range(255, 1));
        s.push_back(b);
      end
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
      got_q.delete();
      model_frame(s);
      send(s, 2);
      n_tests++;
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      foreach (exp_q[i]) if (bad == 0 && got_q[i] !== exp_q[i]) bad = 2 + i;
      if (bad != 0 || {done, error, cpu_hold, byte_count} !== {exp_done, exp_error, !exp_done, 10'(exp_count)}) begin
        n_fail++;
        $display("FAIL random_frame_%0d: len=%0d writes %0d/%0d status %b want %b (code %0d)",
                 f, len, got_q.size(), exp_q.size(), {done, error, cpu_hold, byte_count},
                 {exp_done, exp_error, !exp_done, 10'(exp_count)}, bad);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_errors();
    test_resync_gaps();
    test_reset_mid_frame();
    test_restart();
    test_max_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
